regfile_access_arbiter: RTL and testbench
=========================================

# regfile_access_arbiter

Sequencer and arbiter in front of the 32×32 integer register file of the kianv multicycle rv32ima core. After reset it walks the file, clearing x1..x31 and loading x2 (sp) with STACKADDR. It then shares the file's two read ports and single write port between the core datapath and a debug requester, one granted transaction per cycle. The core has priority, and a bounded-wait counter keeps the debug requester from starving.

## Interface
Parameters:
- REGISTER_WIDTH, 32, data width of every register
- STACKADDR, 32'hffff_ffff, value written to x2 during the init sweep
- STARVE_LIMIT, 4, consecutive denied debug cycles before debug wins over the core (1..15)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- init_done  out  1  high once the init sweep has completed
- core_valid  in  1  core requests a transaction this cycle
- core_ready  out  1  core transaction accepted this cycle (combinational)
- core_we  in  1  core write enable
- core_ra1, core_ra2  in  5  core read addresses
- core_wa  in  5  core write address
- core_wd  in  REGISTER_WIDTH  core write data
- core_rd1, core_rd2  out  REGISTER_WIDTH  pass-through of rf_rd1/rf_rd2
- dbg_valid  in  1  debug request
- dbg_ready  out  1  debug request accepted this cycle (combinational)
- dbg_we  in  1  debug write (1) or read (0)
- dbg_addr  in  5  debug register index
- dbg_wd  in  REGISTER_WIDTH  debug write data
- dbg_rvalid  out  1  registered one-cycle strobe qualifying dbg_rdata
- dbg_rdata  out  REGISTER_WIDTH  registered debug read data
- rf_we  out  1  register file write enable
- rf_A1, rf_A2, rf_A3  out  5  register file addresses
- rf_wd  out  REGISTER_WIDTH  register file write data
- rf_rd1, rf_rd2  in  REGISTER_WIDTH  register file combinational read data

## Operation
- States: INIT and RUN.
- Reset forces INIT, idx=1, wait_cnt=0, init_done=0, dbg_rvalid=0, dbg_rdata=0.
- While reset is high, rf_we=0, core_ready=0 and dbg_ready=0.
- INIT:
  - Each cycle: rf_we=1, rf_A3=idx, rf_wd = (idx==2) ? STACKADDR : 0.
  - idx increments from 1 to 31. The write of idx=31 moves the FSM to RUN and sets init_done=1.
  - core_ready and dbg_ready stay 0 throughout, and valid inputs are ignored.
- RUN grant rules, evaluated combinationally each cycle:
  - dbg_grant = dbg_valid && (!core_valid || wait_cnt==STARVE_LIMIT).
  - core_grant = core_valid && !dbg_grant.
  - The two grants are mutually exclusive. core_ready=core_grant and dbg_ready=dbg_grant.
- Core granted:
  - rf_A1=core_ra1, rf_A2=core_ra2, rf_A3=core_wa, rf_wd=core_wd, rf_we=core_we.
- Debug granted:
  - rf_A1=dbg_addr, rf_A3=dbg_addr, rf_wd=dbg_wd, rf_we=dbg_we.
  - On a read, dbg_rdata<=rf_rd1 and dbg_rvalid<=1 at the next edge.
- No grant: rf_we=0, and rf_A1/rf_A2 track core_ra1/core_ra2 so the core can peek at operands without a handshake.
- core_rd1/core_rd2 always follow rf_rd1/rf_rd2. Their contents are meaningful only when rf_A1/rf_A2 carry core addresses.
- wait_cnt (4 bits):
  - +1 in RUN when dbg_valid && !dbg_grant.
  - Cleared on dbg_grant.
  - Saturates at STARVE_LIMIT.
- dbg_rvalid is high for exactly one cycle per debug read and 0 otherwise. dbg_rdata holds its value until the next debug read.
- Writes to x0 from either side are forwarded unchanged. The register file drops them, and reads of x0 return 0.
- Reset asserted mid-sweep or mid-RUN: immediate return to INIT and a full re-sweep. A debug read in flight is dropped with dbg_rvalid=0.

## Timing
- Init sweep: 31 cycles. The first rf_we pulse is in the first cycle after reset deasserts; init_done is high from cycle 32.
- Core and debug writes take effect at the granting clock edge. Core reads are combinational (zero latency).
- Debug read latency: dbg_rvalid rises 1 cycle after the dbg_ready cycle.
- Worst-case debug wait under continuous core traffic: STARVE_LIMIT denied cycles, then a grant.
- Back-to-back debug transactions are allowed, one per cycle, as long as core_valid=0 or the starvation rule applies.
- A requester holds valid and its payload stable until ready. Ready is never registered.

## Test plan
- Reset release with all valids low -> 31 consecutive rf_we pulses with rf_A3=1..31, rf_wd=32'hffff_ffff only at A3=2; init_done rises cycle 32; debug read of x2 afterwards returns 32'hffff_ffff and x5 returns 0.
- In INIT, hold core_valid=1 and dbg_valid=1 -> ready both 0 until init_done. In RUN, a core write 32'h1234_5678 to x7, then a debug read of x7 -> dbg_rdata=32'h1234_5678, dbg_rvalid one cycle later.
- core_valid held high every cycle with dbg_valid=1 (STARVE_LIMIT=4) -> core_ready for 4 cycles, dbg_ready on cycle 5 with core_ready=0, wait_cnt back to 0, core resumes on cycle 6.
- Debug write 32'hdead_beef to x0, then debug read x0 -> dbg_rdata=0. Debug write to x31 followed by core read x31 on ra2 -> core_rd2=written value.
- Assert reset at sweep cycle 10 for 2 cycles -> rf_we low during reset, sweep restarts at idx=1, init_done stays 0 until 31 cycles after release.
- Debug read granted, then reset asserted before the next edge -> dbg_rvalid stays 0 and dbg_rdata=0.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Register-file front end for the kianv rv32ima core: post-reset clear/SP-load sweep,
// then single-transaction-per-cycle arbitration between the core and a debug requester.
module regfile_access_arbiter #(
  parameter int                        REGISTER_WIDTH = 32,
  parameter logic [REGISTER_WIDTH-1:0] STACKADDR      = 32'hffff_ffff,
  parameter int                        STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      init_done,

  input  logic                      core_valid,
  output logic                      core_ready,
  input  logic                      core_we,
  input  logic [4:0]                core_ra1,
  input  logic [4:0]                core_ra2,
  input  logic [4:0]                core_wa,
  input  logic [REGISTER_WIDTH-1:0] core_wd,
  output logic [REGISTER_WIDTH-1:0] core_rd1,
  output logic [REGISTER_WIDTH-1:0] core_rd2,

  input  logic                      dbg_valid,
  output logic                      dbg_ready,
  input  logic                      dbg_we,
  input  logic [4:0]                dbg_addr,
  input  logic [REGISTER_WIDTH-1:0] dbg_wd,
  output logic                      dbg_rvalid,
  output logic [REGISTER_WIDTH-1:0] dbg_rdata,

  output logic                      rf_we,
  output logic [4:0]                rf_A1,
  output logic [4:0]                rf_A2,
  output logic [4:0]                rf_A3,
  output logic [REGISTER_WIDTH-1:0] rf_wd,
  input  logic [REGISTER_WIDTH-1:0] rf_rd1,
  input  logic [REGISTER_WIDTH-1:0] rf_rd2
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [0:0] state;
  logic [4:0] idx;
  logic [3:0] wait_cnt;
  logic       run;
  logic       dbg_grant;
  logic       core_grant;
  logic       dbg_rd;

  // Grants are gated by reset directly so nothing is accepted while reset is high.
  assign run        = (state == S_RUN) && !reset;
  assign dbg_grant  = run && dbg_valid && (!core_valid || (wait_cnt == LIMIT));
  assign core_grant = run && core_valid && !dbg_grant;
  assign dbg_rd     = dbg_grant && !dbg_we;

  assign core_ready = core_grant;
  assign dbg_ready  = dbg_grant;
  assign core_rd1   = rf_rd1;
  assign core_rd2   = rf_rd2;

  // Read ports default to the core operands so the core can peek without a grant.
  always_comb begin
    rf_we = 1'b0;
    rf_A1 = core_ra1;
    rf_A2 = core_ra2;
    rf_A3 = core_wa;
    rf_wd = core_wd;
    if (state == S_INIT) begin
      rf_we = !reset;
      rf_A3 = idx;
      rf_wd = (idx == 5'd2) ? STACKADDR : '0;
    end else if (dbg_grant) begin
      rf_we = dbg_we;
      rf_A1 = dbg_addr;
      rf_A3 = dbg_addr;
      rf_wd = dbg_wd;
    end else if (core_grant) begin
      rf_we = core_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      idx        <= 5'd1;
      wait_cnt   <= '0;
      init_done  <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= 1'b0;
      case (state)
        S_INIT: begin
          if (idx == 5'd31) begin
            state     <= S_RUN;
            init_done <= 1'b1;
            idx       <= 5'd1;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: begin
          if (dbg_grant)
            wait_cnt <= '0;
          else if (dbg_valid && (wait_cnt != LIMIT))
            wait_cnt <= wait_cnt + 4'd1;
          if (dbg_rd) begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= rf_rd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural 32x32 register file behind it.
module tb_regfile_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        core_valid, core_ready, core_we;
  logic [4:0]  core_ra1, core_ra2, core_wa;
  logic [31:0] core_wd, core_rd1, core_rd2;
  logic        dbg_valid, dbg_ready, dbg_we, dbg_rvalid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wd, dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_A1, rf_A2, rf_A3;
  logic [31:0] rf_wd, rf_rd1, rf_rd2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_access_arbiter dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
    .core_ra1(core_ra1), .core_ra2(core_ra2), .core_wa(core_wa), .core_wd(core_wd),
    .core_rd1(core_rd1), .core_rd2(core_rd2),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wd(dbg_wd), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_A3(rf_A3), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  // Register file: x0 hard-wired to zero, non-zero power-up garbage elsewhere.
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'h5a5a_0000 | i;
  always @(posedge clk) if (rf_we && rf_A3 != 5'd0) mem[rf_A3] <= rf_wd;
  assign rf_rd1 = (rf_A1 == 5'd0) ? 32'd0 : mem[rf_A1];
  assign rf_rd2 = (rf_A2 == 5'd0) ? 32'd0 : mem[rf_A2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic cv, cwe; logic [4:0] ra1, ra2, wa; logic [31:0] cwd;
    logic dv, dwe; logic [4:0] da; logic [31:0] dwd;
    logic cr, dr, we; logic [4:0] a1, a3; logic [31:0] wd;
    logic rv; logic [31:0] rdata;
    logic chk_rd; logic [31:0] rd1, rd2;
  } vec_t;

  function automatic vec_t mk(
    input logic cv, cwe, input logic [4:0] ra1, ra2, wa, input logic [31:0] cwd,
    input logic dv, dwe, input logic [4:0] da, input logic [31:0] dwd,
    input logic cr, dr, we, input logic [4:0] a1, a3, input logic [31:0] wd,
    input logic rv, input logic [31:0] rdata);
    vec_t v;
    v.cv = cv; v.cwe = cwe; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.cwd = cwd;
    v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.cr = cr; v.dr = dr; v.we = we; v.a1 = a1; v.a3 = a3; v.wd = wd;
    v.rv = rv; v.rdata = rdata; v.chk_rd = 1'b0; v.rd1 = '0; v.rd2 = '0;
    return v;
  endfunction

  task automatic idle_inputs();
    core_valid = 0; core_we = 0; core_ra1 = 5'd3; core_ra2 = 5'd4; core_wa = 0; core_wd = 0;
    dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
  endtask

  task automatic sweep(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("sweep_we", {31'd0, rf_we}, 32'd1);
      chk("sweep_a3", {27'd0, rf_A3}, k);
      chk("sweep_wd", rf_wd, (k == 2) ? 32'hffff_ffff : 32'd0);
      chk("sweep_rdy", {30'd0, core_ready, dbg_ready}, 32'd0);
      chk("sweep_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_in_reset(input string nm);
    @(negedge clk);
    chk({nm, "_we"}, {31'd0, rf_we}, 32'd0);
    chk({nm, "_rdy"}, {30'd0, core_ready, dbg_ready}, 32'd0);
    chk({nm, "_done"}, {31'd0, init_done}, 32'd0);
    chk({nm, "_rv"}, {31'd0, dbg_rvalid}, 32'd0);
  endtask

  vec_t vt [20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0,0,3,4,0,0,            1,0,2,0,             0,1,0, 2,0,0,             0,0);
    vt[1]  = mk(0,0,3,4,0,0,            1,0,5,0,             0,1,0, 5,0,0,             1,32'hffff_ffff);
    vt[2]  = mk(1,1,3,4,7,32'h1234_5678, 0,0,0,0,            1,0,1, 3,7,32'h1234_5678, 1,0);
    vt[3]  = mk(0,0,3,4,0,0,            1,0,7,0,             0,1,0, 7,0,0,             0,0);
    vt[4]  = mk(0,0,3,4,0,0,            0,0,0,0,             0,0,0, 3,0,0,             1,32'h1234_5678);
    vt[5]  = mk(0,0,3,4,0,0,            1,1,0,32'hdead_beef, 0,1,1, 0,0,32'hdead_beef, 0,32'h1234_5678);
    vt[6]  = mk(0,0,3,4,0,0,            1,0,0,0,             0,1,0, 0,0,0,             0,32'h1234_5678);
    vt[7]  = mk(0,0,3,4,0,0,            1,1,31,32'hcafe_f00d, 0,1,1, 31,31,32'hcafe_f00d, 1,0);
    vt[8]  = mk(1,0,7,31,0,0,           0,0,0,0,             1,0,0, 7,0,0,             0,0);
    vt[8].chk_rd = 1; vt[8].rd1 = 32'h1234_5678; vt[8].rd2 = 32'hcafe_f00d;
    for (int i = 9; i <= 12; i++)
      vt[i] = mk(1,0,3,4,0,0,           1,0,7,0,             1,0,0, 3,0,0,             0,0);
    vt[13] = mk(1,0,3,4,0,0,            1,0,7,0,             0,1,0, 7,0,0,             0,0);
    vt[14] = mk(1,0,3,4,0,0,            1,0,7,0,             1,0,0, 3,0,0,             1,32'h1234_5678);
    for (int i = 15; i <= 17; i++)
      vt[i] = mk(1,0,3,4,0,0,           1,0,7,0,             1,0,0, 3,0,0,             0,32'h1234_5678);
    vt[18] = mk(1,0,3,4,0,0,            1,0,7,0,             0,1,0, 7,0,0,             0,32'h1234_5678);
    vt[19] = mk(0,0,3,4,0,0,            0,0,0,0,             0,0,0, 3,0,0,             1,32'h1234_5678);

    // Reset with both requesters pushing: nothing may be accepted.
    idle_inputs();
    reset = 1;
    core_valid = 1; core_we = 1; core_wa = 5'd9; core_wd = 32'h1111_1111;
    dbg_valid = 1; dbg_addr = 5'd2;
    chk_in_reset("rst");
    chk("rst_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    sweep(31);
    idle_inputs();
    @(negedge clk);
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("run_idle_we", {31'd0, rf_we}, 32'd0);
    @(posedge clk); #1;

    foreach (vt[i]) begin
      core_valid = vt[i].cv; core_we = vt[i].cwe; core_ra1 = vt[i].ra1; core_ra2 = vt[i].ra2;
      core_wa = vt[i].wa; core_wd = vt[i].cwd;
      dbg_valid = vt[i].dv; dbg_we = vt[i].dwe; dbg_addr = vt[i].da; dbg_wd = vt[i].dwd;
      @(negedge clk);
      chk($sformatf("v%0d_core_ready", i), {31'd0, core_ready}, {31'd0, vt[i].cr});
      chk($sformatf("v%0d_dbg_ready", i), {31'd0, dbg_ready}, {31'd0, vt[i].dr});
      chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vt[i].we});
      chk($sformatf("v%0d_rf_A1", i), {27'd0, rf_A1}, {27'd0, vt[i].a1});
      if (!vt[i].dr) chk($sformatf("v%0d_rf_A2", i), {27'd0, rf_A2}, {27'd0, vt[i].ra2});
      if (vt[i].we) begin
        chk($sformatf("v%0d_rf_A3", i), {27'd0, rf_A3}, {27'd0, vt[i].a3});
        chk($sformatf("v%0d_rf_wd", i), rf_wd, vt[i].wd);
      end
      if (vt[i].chk_rd) begin
        chk($sformatf("v%0d_core_rd1", i), core_rd1, vt[i].rd1);
        chk($sformatf("v%0d_core_rd2", i), core_rd2, vt[i].rd2);
      end
      chk($sformatf("v%0d_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, vt[i].rv});
      chk($sformatf("v%0d_rdata", i), dbg_rdata, vt[i].rdata);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset at sweep cycle 10, held for 2 cycles, then a full re-sweep.
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sweep(9);
    reset = 1;
    chk_in_reset("midrst1");
    @(posedge clk); #1;
    chk_in_reset("midrst2");
    @(posedge clk); #1;
    reset = 0;
    sweep(31);
    @(negedge clk);
    chk("resweep_done", {31'd0, init_done}, 32'd1);
    @(posedge clk); #1;

    // Debug read granted, then reset before the capturing edge: the read is dropped.
    dbg_valid = 1; dbg_we = 0; dbg_addr = 5'd2;
    @(negedge clk);
    chk("inflight_ready", {31'd0, dbg_ready}, 32'd1);
    #2 reset = 1;
    @(posedge clk); #1;
    dbg_valid = 0;
    chk("inflight_rv", {31'd0, dbg_rvalid}, 32'd0);
    chk("inflight_rdata", dbg_rdata, 32'd0);
    chk("inflight_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    chk("inflight_rv2", {31'd0, dbg_rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    sweep(31);
    @(negedge clk);
    chk("final_done", {31'd0, init_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
